// File: rtl/fp32_div_seq.sv
// ============================================================================
// Module      : fp32_div_seq
// Description : Sequential IEEE-754 single-precision divider (q = a / b).
//               Radix-2 restoring mantissa iteration, round-to-nearest-even,
//               valid/ready handshake on both sides.
//               Optional gradual underflow: define FP32_DIV_SUBNORM_EN.
//               Without it, tiny results flush to signed zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_div_seq #(
  parameter int ITER = 27
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] q_o,
  output logic [4:0]  flags_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  localparam logic [4:0]  CNT_LAST = 5'(ITER - 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_DIV   = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        mb_q, mb_d;
  logic [24:0]        rem_q, rem_d;
  logic [26:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic [4:0]         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  // Unpack an operand into {unbiased exponent, 24-bit significand}; subnormals
  // are normalised so the hidden bit is always set.
  function automatic logic [33:0] unpack_op(input logic [31:0] x);
    logic [23:0]       m;
    logic [4:0]        lz;
    logic [4:0]        sh;
    logic              found;
    logic signed [9:0] e;
    m     = {1'b1, x[22:0]};
    lz    = 5'd0;
    sh    = 5'd0;
    found = 1'b0;
    e     = $signed({2'b00, x[30:23]}) - 10'sd127;
    if (x[30:23] == 8'd0) begin
      for (int i = 22; i >= 0; i--) begin
        if (!found && x[i]) begin
          lz    = 5'(22 - i);
          found = 1'b1;
        end
      end
      sh = lz + 5'd1;
      m  = {1'b0, x[22:0]} << sh;
      e  = -10'sd126 - $signed({5'd0, sh});
    end
    return {e, m};
  endfunction

  logic [33:0]       ua, ub;
  logic signed [9:0] ea, eb;
  logic [23:0]       ma, mb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, w_sign;

  assign ua     = unpack_op(a_q);
  assign ub     = unpack_op(b_q);
  assign ea     = ua[33:24];
  assign eb     = ub[33:24];
  assign ma     = ua[23:0];
  assign mb     = ub[23:0];
  assign a_nan  = (&a_q[30:23]) & (|a_q[22:0]);
  assign b_nan  = (&b_q[30:23]) & (|b_q[22:0]);
  assign a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
  assign b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
  assign a_zero = ~(|a_q[30:0]);
  assign b_zero = ~(|b_q[30:0]);
  assign w_sign = a_q[31] ^ b_q[31];

  // Rounding datapath: normalise quotient, round to nearest even, classify range.
  logic [25:0]       qn;
  logic signed [9:0] be, be_r;
  logic              sticky_rem, g, st, inc, carry;
  logic [23:0]       frac_sum;
  logic [22:0]       frac_r;
  logic [31:0]       rnd_res;
  logic [4:0]        rnd_flags;
`ifdef FP32_DIV_SUBNORM_EN
  logic signed [9:0] shr;
  logic [4:0]        shr_c;
  logic [26:0]       v, lost_mask;
  logic              lost, sub_g, sub_st, sub_inc;
  logic [23:0]       sub_sum;
`endif

  always_comb begin
    // qn holds the 26 bits below the leading one after normalisation
    qn         = quo_q[26] ? quo_q[25:0] : {quo_q[24:0], 1'b0};
    be         = (quo_q[26] ? exp_q : exp_q - 10'sd1) + 10'sd127;
    sticky_rem = |rem_q;
    g          = qn[2];
    st         = qn[1] | qn[0] | sticky_rem;
    inc        = g & (st | qn[3]);
    frac_sum   = {1'b0, qn[25:3]} + {23'd0, inc};
    carry      = frac_sum[23];
    be_r       = carry ? be + 10'sd1 : be;
    frac_r     = carry ? 23'd0 : frac_sum[22:0];
`ifdef FP32_DIV_SUBNORM_EN
    // Denormalise by 1 - be; bits pushed out below the round position go to sticky
    shr       = 10'sd1 - be;
    shr_c     = (shr > 10'sd27) ? 5'd27 : shr[4:0];
    v         = {1'b1, qn} >> shr_c;
    lost_mask = (27'd1 << shr_c) - 27'd1;
    lost      = |({1'b1, qn} & lost_mask);
    sub_g     = v[2];
    sub_st    = v[1] | v[0] | lost | sticky_rem;
    sub_inc   = sub_g & (sub_st | v[3]);
    // A carry into bit 23 lands in the exponent field: minimum normal
    sub_sum   = v[26:3] + {23'd0, sub_inc};
`endif
    if (be <= 10'sd0) begin
`ifdef FP32_DIV_SUBNORM_EN
      rnd_res   = {sign_q, 7'd0, sub_sum};
      rnd_flags = {3'b000, sub_g | sub_st, sub_g | sub_st};
`else
      rnd_res   = {sign_q, 31'd0};
      rnd_flags = 5'b00011;
`endif
    end else if (be_r >= 10'sd255) begin
      rnd_res   = {sign_q, 8'hFF, 23'd0};
      rnd_flags = 5'b00101;
    end else begin
      rnd_res   = {sign_q, be_r[7:0], frac_r};
      rnd_flags = {4'b0000, g | st};
    end
  end

  // Next-state and datapath update for the control sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mb_d        = mb_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sign_d  = w_sign;
        exp_d   = ea - eb;
        mb_d    = mb;
        rem_d   = {1'b0, ma};
        quo_d   = 27'd0;
        cnt_d   = CNT_LAST;
        state_d = S_DONE;
        if (a_nan | b_nan) begin
          res_d   = QNAN;
          flags_d = 5'b00000;
        end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
          res_d   = QNAN;
          flags_d = 5'b10000;
        end else if (a_inf) begin
          res_d   = {w_sign, 8'hFF, 23'd0};
          flags_d = 5'b00000;
        end else if (b_zero) begin
          res_d   = {w_sign, 8'hFF, 23'd0};
          flags_d = 5'b01000;
        end else if (a_zero | b_inf) begin
          res_d   = {w_sign, 31'd0};
          flags_d = 5'b00000;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (rem_q >= {1'b0, mb_q}) begin
          rem_d = (rem_q - {1'b0, mb_q}) << 1;
          quo_d = {quo_q[25:0], 1'b1};
        end else begin
          rem_d = rem_q << 1;
          quo_d = {quo_q[25:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        res_d   = rnd_res;
        flags_d = rnd_flags;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      sign_q      <= 1'b0;
      exp_q       <= 10'sd0;
      mb_q        <= 24'd0;
      rem_q       <= 25'd0;
      quo_q       <= 27'd0;
      cnt_q       <= 5'd0;
      res_q       <= 32'd0;
      flags_q     <= 5'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mb_q        <= mb_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign q_o         = res_q;
  assign flags_o     = flags_q;
  assign out_valid_o = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fp32_div_seq.sv
// ============================================================================
// Module      : tb_fp32_div_seq
// Description : Directed self-checking bench for fp32_div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp32_div_seq;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] a_i, b_i;
  logic        in_valid_i, in_ready_o;
  logic [31:0] q_o;
  logic [4:0]  flags_o;
  logic        out_valid_o, out_ready_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp32_div_seq dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .q_o         (q_o),
    .flags_o     (flags_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  // Present operands and return #1 after the capture edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (in_ready_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    a_i = a; b_i = b; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  // Count rising edges from the capture edge until out_valid_o is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic accept();
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
    checks++; if (q_o !== 32'h0) begin errors++; $display("FAIL reset_q: got %h expected 00000000", q_o); end
    checks++; if (flags_o !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", flags_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_normal();
    logic [31:0] ta [5], tb [5], tq [5];
    logic [4:0]  tf [5];
    int lat;
    ta = '{32'h3F800000, 32'h3F800000, 32'h40C00000, 32'hBF800000, 32'hFF7FFFFF};
    tb = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h40400000, 32'h3E800000};
    tq = '{32'h3F000000, 32'h3EAAAAAB, 32'h40800000, 32'hBEAAAAAB, 32'hFF800000};
    tf = '{5'b00000,     5'b00001,     5'b00000,     5'b00001,     5'b00101};
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb[i]);
      wait_valid(lat);
      checks++; if (lat !== 30) begin errors++; $display("FAIL normal_lat[%0d]: got %0d expected 30", i, lat); end
      checks++; if (q_o !== tq[i]) begin errors++; $display("FAIL normal_q[%0d]: got %h expected %h", i, q_o, tq[i]); end
      checks++; if (flags_o !== tf[i]) begin errors++; $display("FAIL normal_flags[%0d]: got %b expected %b", i, flags_o, tf[i]); end
      accept();
    end
  endtask

  task automatic test_overflow();
    int lat;
    start_op(32'h7F7FFFFF, 32'h3E800000);
    wait_valid(lat);
    checks++; if (lat !== 30) begin errors++; $display("FAIL ovf_lat: got %0d expected 30", lat); end
    checks++; if (q_o !== 32'h7F800000) begin errors++; $display("FAIL ovf_q: got %h expected 7f800000", q_o); end
    checks++; if (flags_o !== 5'b00101) begin errors++; $display("FAIL ovf_flags: got %b expected 00101", flags_o); end
    accept();
  endtask

  task automatic test_specials();
    logic [31:0] ta [8], tb [8], tq [8];
    logic [4:0]  tf [8];
    int lat;
    ta = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7FC00001,
           32'h7F800000, 32'h80000000, 32'h3F800000, 32'hBF800000};
    tb = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F800000,
           32'h40000000, 32'h40A00000, 32'hFF800000, 32'h00000000};
    tq = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
           32'h7F800000, 32'h80000000, 32'h80000000, 32'hFF800000};
    tf = '{5'b01000, 5'b10000, 5'b10000, 5'b00000,
           5'b00000, 5'b00000, 5'b00000, 5'b01000};
    for (int i = 0; i < 8; i++) begin
      start_op(ta[i], tb[i]);
      wait_valid(lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL special_lat[%0d]: got %0d expected 2", i, lat); end
      checks++; if (q_o !== tq[i]) begin errors++; $display("FAIL special_q[%0d]: got %h expected %h", i, q_o, tq[i]); end
      checks++; if (flags_o !== tf[i]) begin errors++; $display("FAIL special_flags[%0d]: got %b expected %b", i, flags_o, tf[i]); end
      accept();
    end
  endtask

  task automatic test_underflow();
    logic [31:0] ta [3], tb [3], tq [3];
    logic [4:0]  tf [3];
    int lat;
    ta = '{32'h00800000, 32'h00FFFFFF, 32'h00000001};
    tb = '{32'h40000000, 32'h40000000, 32'h3F800000};
`ifdef FP32_DIV_SUBNORM_EN
    tq = '{32'h00400000, 32'h00800000, 32'h00000001};
    tf = '{5'b00000,     5'b00011,     5'b00000};
`else
    tq = '{32'h00000000, 32'h00000000, 32'h00000000};
    tf = '{5'b00011,     5'b00011,     5'b00011};
`endif
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i]);
      wait_valid(lat);
      checks++; if (lat !== 30) begin errors++; $display("FAIL unf_lat[%0d]: got %0d expected 30", i, lat); end
      checks++; if (q_o !== tq[i]) begin errors++; $display("FAIL unf_q[%0d]: got %h expected %h", i, q_o, tq[i]); end
      checks++; if (flags_o !== tf[i]) begin errors++; $display("FAIL unf_flags[%0d]: got %b expected %b", i, flags_o, tf[i]); end
      accept();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(32'h3F800000, 32'h40400000);
    wait_valid(lat);
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got %b expected 1", out_valid_o); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (q_o !== 32'h3EAAAAAB) begin errors++; $display("FAIL bp_q[%0d]: got %h expected 3eaaaaab", i, q_o); end
      checks++; if (flags_o !== 5'b00001) begin errors++; $display("FAIL bp_flags[%0d]: got %b expected 00001", i, flags_o); end
      checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready_o); end
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid_o); end
    end
    accept();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready_o); end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    logic seen;
    start_op(32'h3F800000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid_o); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid_o !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_ghost_result: got %b expected 0", seen); end
    start_op(32'h3F800000, 32'h40000000);
    wait_valid(lat);
    checks++; if (lat !== 30) begin errors++; $display("FAIL rst_after_lat: got %0d expected 30", lat); end
    checks++; if (q_o !== 32'h3F000000) begin errors++; $display("FAIL rst_after_q: got %h expected 3f000000", q_o); end
    checks++; if (flags_o !== 5'b00000) begin errors++; $display("FAIL rst_after_flags: got %b expected 00000", flags_o); end
    accept();
  endtask

  initial begin
    rst_i       = 1'b1;
    a_i         = 32'd0;
    b_i         = 32'd0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    test_reset();
    test_normal();
    test_overflow();
    test_specials();
    test_underflow();
    test_backpressure();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
